// File: rtl/arith_issue_stage.sv
// Issue stage ahead of the arithmetic unit: a request FIFO whose head drives the unit,
// and a tagged result register with its own valid/ready handshake.
module arith_issue_stage #(
    parameter int OPERAND_WIDTH = 32,
    parameter int DEPTH         = 4,
    parameter int TAG_WIDTH     = 4
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_op,
    input  logic [OPERAND_WIDTH-1:0]   in_lhs,
    input  logic [OPERAND_WIDTH-1:0]   in_rhs,
    input  logic [TAG_WIDTH-1:0]       in_tag,

    output logic [1:0]                 arith_op,
    output logic [OPERAND_WIDTH-1:0]   arith_lhs,
    output logic [OPERAND_WIDTH-1:0]   arith_rhs,
    input  logic [OPERAND_WIDTH-1:0]   arith_res,

    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OPERAND_WIDTH-1:0]   out_res,
    output logic [TAG_WIDTH-1:0]       out_tag,
    output logic                       out_illegal,

    output logic [$clog2(DEPTH):0]     occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [1:0]               op_mem  [DEPTH];
    logic [OPERAND_WIDTH-1:0] lhs_mem [DEPTH];
    logic [OPERAND_WIDTH-1:0] rhs_mem [DEPTH];
    logic [TAG_WIDTH-1:0]     tag_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic fifo_empty;
    logic push;
    logic pop;

    logic [1:0]               head_op;
    logic [OPERAND_WIDTH-1:0] head_lhs;
    logic [OPERAND_WIDTH-1:0] head_rhs;
    logic [TAG_WIDTH-1:0]     head_tag;

    // Readiness depends only on the registered count, never on out_ready.
    assign fifo_empty = (count == '0);
    assign in_ready   = (count != FULL_CNT);
    assign push       = in_valid & in_ready;
    assign pop        = ~fifo_empty & (~out_valid | out_ready);
    assign occupancy  = count;

    assign head_op  = op_mem[rd_ptr];
    assign head_lhs = lhs_mem[rd_ptr];
    assign head_rhs = rhs_mem[rd_ptr];
    assign head_tag = tag_mem[rd_ptr];

    // Empty FIFO presents zeros so the arithmetic unit never sees stale operands.
    assign arith_op  = fifo_empty ? 2'b00 : head_op;
    assign arith_lhs = fifo_empty ? '0    : head_lhs;
    assign arith_rhs = fifo_empty ? '0    : head_rhs;

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr]  <= in_op;
            lhs_mem[wr_ptr] <= in_lhs;
            rhs_mem[wr_ptr] <= in_rhs;
            tag_mem[wr_ptr] <= in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_res     <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
        end else if (pop) begin
            out_valid   <= 1'b1;
            out_res     <= head_op[1] ? '0 : arith_res;
            out_tag     <= head_tag;
            out_illegal <= head_op[1];
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arith_issue_stage.sv
// Scoreboard bench for arith_issue_stage: stimulus pushes expected results, a monitor
// pops and compares them and tracks a cycle-level occupancy/valid model.
module tb_arith_issue_stage;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_op;
    logic [W-1:0]  in_lhs;
    logic [W-1:0]  in_rhs;
    logic [TW-1:0] in_tag;
    logic [1:0]    arith_op;
    logic [W-1:0]  arith_lhs;
    logic [W-1:0]  arith_rhs;
    logic [W-1:0]  arith_res;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_res;
    logic [TW-1:0] out_tag;
    logic          out_illegal;
    logic [$clog2(D):0] occupancy;

    arith_issue_stage #(.OPERAND_WIDTH(W), .DEPTH(D), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_lhs(in_lhs), .in_rhs(in_rhs), .in_tag(in_tag),
        .arith_op(arith_op), .arith_lhs(arith_lhs), .arith_rhs(arith_rhs),
        .arith_res(arith_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_tag(out_tag), .out_illegal(out_illegal), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Arithmetic unit stand-in; illegal ops produce garbage the stage must suppress.
    always_comb begin
        case (arith_op)
            2'b00:   arith_res = arith_lhs + arith_rhs;
            2'b01:   arith_res = arith_lhs - arith_rhs;
            default: arith_res = arith_lhs ^ 32'hDEAD_BEEF;
        endcase
    end

    typedef struct {
        logic [1:0]    op;
        logic [W-1:0]  lhs;
        logic [W-1:0]  rhs;
        logic [TW-1:0] tag;
        logic [W-1:0]  res;
        logic          ill;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_cnt    = 0;
    bit   m_ov     = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic exp_t make_exp(input logic [1:0] op, input logic [W-1:0] a,
                                      input logic [W-1:0] b, input logic [TW-1:0] t);
        exp_t e;
        e.op  = op;
        e.lhs = a;
        e.rhs = b;
        e.tag = t;
        e.ill = op[1];
        if (op[1])        e.res = '0;
        else if (op == 0) e.res = a + b;
        else              e.res = a - b;
        return e;
    endfunction

    task automatic drive_cycle(input logic v, input logic [1:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [TW-1:0] t,
                               input logic ordy, output bit acc);
        @(negedge clk);
        in_valid  = v;
        in_op     = op;
        in_lhs    = a;
        in_rhs    = b;
        in_tag    = t;
        out_ready = ordy;
        #1;
        acc = v && in_ready && !rst;
        if (acc) sb.push_back(make_exp(op, a, b, t));
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [TW-1:0] t, input logic ordy);
        bit acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) drive_cycle(1'b1, op, a, b, t, ordy, acc);
        check("send_accept", 64'(acc), 64'd1);
    endtask

    task automatic idle(input int n, input logic ordy);
        bit acc;
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 2'b00, '0, '0, '0, ordy, acc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_res", 64'(out_res), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_illegal", 64'(out_illegal), 64'd0);
        check("rst_arith_lhs", 64'(arith_lhs), 64'd0);
    endtask

    // Monitor: samples 2 time units before each rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                m_cnt = 0;
                m_ov  = 1'b0;
                sb.delete();
            end else begin
                int  hi;
                bit  mpush, mpop;
                check("in_ready", 64'(in_ready), 64'(m_cnt != D));
                check("occupancy", 64'(occupancy), 64'(m_cnt));
                check("out_valid", 64'(out_valid), 64'(m_ov));
                hi = m_ov ? 1 : 0;
                if (m_cnt == 0) begin
                    check("arith_idle", {30'd0, arith_op, arith_lhs}, 64'd0);
                    check("arith_rhs_idle", 64'(arith_rhs), 64'd0);
                end else if (sb.size() > hi) begin
                    check("arith_op", 64'(arith_op), 64'(sb[hi].op));
                    check("arith_lhs", 64'(arith_lhs), 64'(sb[hi].lhs));
                    check("arith_rhs", 64'(arith_rhs), 64'(sb[hi].rhs));
                end
                if (out_valid && out_ready) begin
                    check("result_expected", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        check("out_tag", 64'(out_tag), 64'(e.tag));
                        check("out_res", 64'(out_res), 64'(e.res));
                        check("out_illegal", 64'(out_illegal), 64'(e.ill));
                    end
                end
                mpush = in_valid && (m_cnt < D);
                mpop  = (m_cnt > 0) && (!m_ov || out_ready);
                if (mpop)           m_ov = 1'b1;
                else if (out_ready) m_ov = 1'b0;
                m_cnt = m_cnt + int'(mpush) - int'(mpop);
            end
        end
    end

    initial begin
        bit acc;
        int acc_cnt;
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_lhs = '0; in_rhs = '0;
        in_tag = '0; out_ready = 1'b0;
        do_reset();

        send(2'b00, 32'd5, 32'd3, 4'd1, 1'b1);
        idle(3, 1'b1);
        send(2'b01, 32'd0, 32'd1, 4'd2, 1'b1);
        send(2'b00, 32'hFFFF_FFFF, 32'd1, 4'd5, 1'b1);
        idle(3, 1'b1);

        acc_cnt = 0;
        for (int t = 0; t < 8; t++) begin
            drive_cycle(1'b1, 2'b00, W'(t * 10), W'(t), TW'(t), 1'b0, acc);
            acc_cnt += int'(acc);
        end
        check("bp_accepted", 64'(acc_cnt), 64'd5);
        for (int t = 5; t < 8; t++) send(2'b00, W'(t * 10), W'(t), TW'(t), 1'b1);
        idle(8, 1'b1);

        for (int t = 0; t < 5; t++) send(2'b01, W'(100 + t), W'(t), TW'(t), 1'b0);
        for (int t = 5; t < 11; t++) send(2'b00, W'(t), W'(t * 3), TW'(t), 1'b1);
        idle(8, 1'b1);

        send(2'b10, 32'd7, 32'd9, 4'd3, 1'b1);
        send(2'b00, 32'd10, 32'd20, 4'd4, 1'b1);
        idle(4, 1'b1);

        for (int t = 9; t < 13; t++) send(2'b00, W'(t), W'(t), TW'(t), 1'b0);
        do_reset();
        send(2'b00, 32'd1, 32'd2, 4'd6, 1'b1);
        send(2'b01, 32'd9, 32'd4, 4'd7, 1'b1);
        idle(4, 1'b1);

        for (int i = 0; i < 400; i++) begin
            logic [1:0] op;
            int r;
            r  = int'($urandom_range(0, 7));
            op = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r == 6) ? 2'b10 : 2'b11;
            drive_cycle(($urandom_range(0, 9) < 7), op,
                        ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom,
                        ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom,
                        TW'($urandom), ($urandom_range(0, 9) < 6), acc);
        end

        for (int i = 0; i < 50 && sb.size() != 0; i++) idle(1, 1'b1);
        idle(2, 1'b1);
        check("drain_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/arith_issue_stage.md
# arith_issue_stage

Buffered issue stage directly upstream of the arithmetic unit. Accepts add/sub requests over a valid/ready handshake and queues them in a DEPTH-entry FIFO. Presents the head entry's op/lhs/rhs to the arithmetic unit and captures the combinational result into a registered, tagged output with its own valid/ready handshake. Decouples the decode front end from result consumers, sustaining one operation per cycle.

## Interface
- OPERAND_WIDTH, 32, operand and result bit width
- DEPTH, 4, FIFO entries; power of two, ≥2
- TAG_WIDTH, 4, width of the opaque request tag carried with each operation
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  request present
- in_ready  output  1  stage can accept a request this cycle
- in_op  input  2  2'b00 add, 2'b01 sub, 2'b1x illegal
- in_lhs / in_rhs  input  OPERAND_WIDTH  operands
- in_tag  input  TAG_WIDTH  request tag
- arith_op  output  2  op driven to the arithmetic unit
- arith_lhs / arith_rhs  output  OPERAND_WIDTH  operands driven to the arithmetic unit
- arith_res  input  OPERAND_WIDTH  combinational result from the arithmetic unit
- out_valid  output  1  result register holds a result
- out_ready  input  1  consumer accepts the result
- out_res  output  OPERAND_WIDTH  result
- out_tag  output  TAG_WIDTH  tag of the result
- out_illegal  output  1  result came from an illegal op
- occupancy  output  $clog2(DEPTH)+1  FIFO entries held; excludes the output register

## Operation
- Push: in_valid & in_ready stores {op, lhs, rhs, tag} at the write pointer.
- in_ready = (occupancy != DEPTH). No combinational dependence on out_ready: a full FIFO refuses even when a pop happens in the same cycle.
- Head drive: FIFO non-empty drives the head entry onto arith_op/lhs/rhs. FIFO empty drives arith_op = 0 and arith_lhs = arith_rhs = 0.
- Pop condition: FIFO non-empty & (!out_valid | out_ready).
- On pop: out_res ← arith_res (forced to 0 if head op[1] = 1), out_tag ← head tag, out_illegal ← head op[1], out_valid ← 1.
- out_valid & out_ready with no pop → out_valid ← 0. Output fields hold their last values.
- out_valid & !out_ready → all out_* held stable.
- Push and pop in the same cycle: occupancy unchanged.
- Both pointers wrap modulo DEPTH.
- Results leave in acceptance order.
- Arithmetic is modulo 2^OPERAND_WIDTH, computed entirely by the arithmetic unit. This block never alters legal results.
- Illegal ops are accepted and complete in order, with out_illegal = 1 and out_res = 0.

## Timing
- Reset values: out_valid = 0, out_res = 0, out_tag = 0, out_illegal = 0, occupancy = 0, in_ready = 1, both pointers = 0.
- Reset discards all queued entries and any pending output, regardless of handshake state.
- Latency: request accepted at edge N on an empty stage with a free output register → head drives arith_* after edge N → out_valid = 1 after edge N+1 (2 cycles).
- Throughput: 1 op/cycle while out_ready = 1.
- Capacity: DEPTH + 1 in-flight operations (FIFO plus output register).
- Inputs are sampled only on the handshake edge. in_* are don't-care when in_valid = 0.
- arith_* change only after a clock edge and are glitch-free relative to the registered FIFO state.

## Test plan
- Single add, DEPTH = 4, out_ready = 1: accept add 5 + 3, tag 1 at edge 0 → out_valid = 1 after edge 1 with out_res = 8, out_tag = 1. out_valid = 0 the next cycle.
- Sub wrap, OPERAND_WIDTH = 32: sub 0 − 1, tag 2 → out_res = 0xFFFF_FFFF, out_illegal = 0. Then add 0xFFFF_FFFF + 1 → out_res = 0.
- Backpressure, DEPTH = 4, out_ready = 0, back-to-back requests tags 0..7 → exactly 5 accepted, with in_ready = 0 and occupancy = 4. Raise out_ready → tags 0,1,2,3,4 emerge on consecutive cycles with correct sums. Tags 5..7 are accepted as space frees, preserving order.
- Full with simultaneous pop: FIFO full with out_ready = 1 and in_valid held → no push on the first drain cycle (in_ready = 0). Thereafter occupancy stays at DEPTH − 1 with one push and one pop per cycle.
- Illegal op: in_op = 2'b10, lhs = 7, rhs = 9, tag 3 → out_illegal = 1, out_res = 0, out_tag = 3. The following add completes normally.
- Reset mid-stream: 3 queued entries plus a stalled output, assert rst for 1 cycle → next cycle out_valid = 0, occupancy = 0, in_ready = 1, arith_* = 0. None of the old tags ever appear.
